// File: rtl/hazard_unit_mc.sv
// Hazard unit for a five-stage pipeline with a multi-cycle data memory: operand
// bypass selection, load-use / redirect / memory-wait stall and flush control, perf counters.
module hazard_unit_mc #(
   parameter int unsigned REG_AW  = 5,
   parameter int unsigned MEM_LAT = 2,
   parameter int unsigned CNT_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] Rs1D,
   input  logic [REG_AW-1:0] Rs2D,
   input  logic [REG_AW-1:0] Rs1E,
   input  logic [REG_AW-1:0] Rs2E,
   input  logic [REG_AW-1:0] RdE,
   input  logic [REG_AW-1:0] RdM,
   input  logic [REG_AW-1:0] RdW,
   input  logic              RegWriteM,
   input  logic              RegWriteW,
   input  logic [1:0]        ResultSrcE,
   input  logic              PCSrcE,
   input  logic              MemAccessM,
   input  logic              perf_clr,
   output logic [1:0]        ForwardAE,
   output logic [1:0]        ForwardBE,
   output logic              StallF,
   output logic              StallD,
   output logic              StallE,
   output logic              StallM,
   output logic              FlushD,
   output logic              FlushE,
   output logic              FlushW,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   typedef enum logic [1:0] {IDLE, WAIT, RELEASE} state_t;

   localparam logic [3:0] LAT_M1 = (MEM_LAT > 0) ? 4'(MEM_LAT - 1) : 4'd0;

   state_t           state_q, state_d;
   logic [3:0]       wcnt_q, wcnt_d;
   logic             mem_stall;
   logic             lw_stall;
   logic [1:0]       fwd_a, fwd_b;
   logic             stall_f, stall_d, stall_e, stall_m;
   logic             flush_d, flush_e, flush_w;
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   // Memory stage wins the bypass over Writeback because it holds the younger result.
   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (RegWriteM && (RdM != '0) && (RdM == Rs1E))      fwd_a = 2'b10;
      else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) fwd_a = 2'b01;
      if (RegWriteM && (RdM != '0) && (RdM == Rs2E))      fwd_b = 2'b10;
      else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) fwd_b = 2'b01;
   end

   assign lw_stall = (ResultSrcE == 2'b01) && (RdE != '0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D));

   // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      mem_stall = 1'b0;
      case (state_q)
         IDLE: begin
            if (MemAccessM && (MEM_LAT != 0)) begin
               mem_stall = 1'b1;
               wcnt_d    = LAT_M1;
               state_d   = (MEM_LAT == 1) ? RELEASE : WAIT;
            end
         end
         WAIT: begin
            mem_stall = 1'b1;
            wcnt_d    = wcnt_q - 4'd1;
            if (wcnt_q == 4'd1) state_d = RELEASE;
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         wcnt_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end

   // A frozen Execute keeps PCSrcE alive, so the redirect lands once the memory wait ends.
   always_comb begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      stall_m = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_w = 1'b0;
      if (mem_stall) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         stall_e = 1'b1;
         stall_m = 1'b1;
         flush_w = 1'b1;
      end else if (PCSrcE) begin
         flush_d = 1'b1;
         flush_e = 1'b1;
      end else if (lw_stall) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         flush_e = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else if (perf_clr) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_f && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (flush_e && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   // Reset forces every control output quiet regardless of the pipeline inputs.
   assign ForwardAE = reset ? 2'b00 : fwd_a;
   assign ForwardBE = reset ? 2'b00 : fwd_b;
   assign StallF    = stall_f & ~reset;
   assign StallD    = stall_d & ~reset;
   assign StallE    = stall_e & ~reset;
   assign StallM    = stall_m & ~reset;
   assign FlushD    = flush_d & ~reset;
   assign FlushE    = flush_e & ~reset;
   assign FlushW    = flush_w & ~reset;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Scoreboard bench for hazard_unit_mc (MEM_LAT=2, CNT_W=4): expected outputs are queued
// when a stimulus cycle is driven and popped at the following falling edge.
module tb_hazard_unit_mc;

   localparam int REG_AW  = 5;
   localparam int MEM_LAT = 2;
   localparam int CNT_W   = 4;

   typedef struct packed {
      logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
      logic       rwm, rww;
      logic [1:0] rsrc;
      logic       pcsrc, mem, clr;
   } in_t;

   typedef struct packed {
      logic [1:0] fa, fb;
      logic       sf, sd, se, sm, fd, fe, fw;
   } out_t;

   logic              clk;
   logic              reset;
   logic [REG_AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic              RegWriteM, RegWriteW;
   logic [1:0]        ResultSrcE;
   logic              PCSrcE, MemAccessM, perf_clr;
   logic [1:0]        ForwardAE, ForwardBE;
   logic              StallF, StallD, StallE, StallM;
   logic              FlushD, FlushE, FlushW;
   logic [CNT_W-1:0]  stall_cnt, flush_cnt;

   out_t       sb[$];
   int         checks = 0;
   int         passed = 0;
   logic [3:0] m_stall = 4'd0;
   logic [3:0] m_flush = 4'd0;

   hazard_unit_mc #(.REG_AW(REG_AW), .MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE),
      .PCSrcE(PCSrcE), .MemAccessM(MemAccessM), .perf_clr(perf_clr),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic apply(input in_t s);
      Rs1D = s.rs1d; Rs2D = s.rs2d; Rs1E = s.rs1e; Rs2E = s.rs2e;
      RdE = s.rde; RdM = s.rdm; RdW = s.rdw;
      RegWriteM = s.rwm; RegWriteW = s.rww; ResultSrcE = s.rsrc;
      PCSrcE = s.pcsrc; MemAccessM = s.mem; perf_clr = s.clr;
   endtask

   // Inputs change 1 time unit after the rising edge; the expectation is queued with them.
   task automatic drive(input in_t s, input out_t e);
      @(posedge clk);
      #1;
      apply(s);
      sb.push_back(e);
   endtask

   function automatic out_t sample();
      out_t o;
      o.fa = ForwardAE; o.fb = ForwardBE;
      o.sf = StallF; o.sd = StallD; o.se = StallE; o.sm = StallM;
      o.fd = FlushD; o.fe = FlushE; o.fw = FlushW;
      return o;
   endfunction

   function automatic out_t mem_out(input logic [1:0] fa);
      out_t o;
      o = '0;
      o.fa = fa; o.sf = 1'b1; o.sd = 1'b1; o.se = 1'b1; o.sm = 1'b1; o.fw = 1'b1;
      return o;
   endfunction

   function automatic out_t lw_out();
      out_t o;
      o = '0;
      o.sf = 1'b1; o.sd = 1'b1; o.fe = 1'b1;
      return o;
   endfunction

   function automatic out_t redir_out();
      out_t o;
      o = '0;
      o.fd = 1'b1; o.fe = 1'b1;
      return o;
   endfunction

   function automatic in_t lw_in();
      in_t s;
      s = '0;
      s.rsrc = 2'b01; s.rde = 5'd3; s.rs2d = 5'd3;
      return s;
   endfunction

   // Reference counters: advance at the edge that ends the cycle whose expectation is e.
   task automatic model_cnt(input logic clr, input out_t e);
      if (clr) begin
         m_stall = 4'd0;
         m_flush = 4'd0;
      end else begin
         if (e.sf && (m_stall != 4'hF)) m_stall = m_stall + 4'd1;
         if (e.fe && (m_flush != 4'hF)) m_flush = m_flush + 4'd1;
      end
   endtask

   task automatic test_reset();
      in_t  s;
      out_t e, got, z;
      z = '0;
      s = lw_in();
      s.rs1e = 5'd5; s.rdm = 5'd5; s.rwm = 1'b1; s.rs2e = 5'd6; s.rdw = 5'd6; s.rww = 1'b1;
      s.pcsrc = 1'b1; s.mem = 1'b1;
      reset = 1'b1;
      apply(s);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         sb.push_back(z);
         got = sample();
         e = sb.pop_front();
         checks++;
         if (got !== e) $display("FAIL reset_outputs cycle %0d: got %b expected %b", k, got, e);
         else passed++;
         checks++;
         if ((stall_cnt !== 4'd0) || (flush_cnt !== 4'd0))
            $display("FAIL reset_counters cycle %0d: got %0d/%0d expected 0/0", k, stall_cnt, flush_cnt);
         else passed++;
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      s = '0;
      apply(s);
      m_stall = 4'd0;
      m_flush = 4'd0;
      sb.push_back(z);
      @(negedge clk);
      got = sample();
      e = sb.pop_front();
      checks++;
      if (got !== e) $display("FAIL reset_release: got %b expected %b", got, e);
      else passed++;
   endtask

   task automatic test_forwarding();
      in_t  s;
      out_t e, got;
      for (int k = 0; k < 7; k++) begin
         s = '0;
         e = '0;
         case (k)
            0: begin s.rs1e = 5; s.rdm = 5; s.rdw = 5; s.rwm = 1; s.rww = 1; e.fa = 2'b10; end
            1: begin s.rs1e = 5; s.rdm = 0; s.rdw = 5; s.rwm = 1; s.rww = 1; e.fa = 2'b01; end
            2: begin s.rs1e = 7; s.rs2e = 0; s.rdm = 0; s.rdw = 0; s.rwm = 1; s.rww = 1; end
            3: begin s.rs1e = 6; s.rs2e = 9; s.rdm = 6; s.rdw = 9; s.rwm = 1; s.rww = 1;
                     e.fa = 2'b10; e.fb = 2'b01; end
            4: begin s.rs1e = 6; s.rs2e = 9; s.rdm = 6; s.rdw = 9; end
            5: begin s.rs1e = 12; s.rs2e = 12; s.rdm = 12; s.rdw = 12; s.rwm = 1; s.rww = 1;
                     e.fa = 2'b10; e.fb = 2'b10; end
            default: begin s.rs1e = 31; s.rdm = 31; s.rdw = 31; s.rww = 1; e.fa = 2'b01; end
         endcase
         drive(s, e);
         @(negedge clk);
         got = sample();
         e = sb.pop_front();
         checks++;
         if (got !== e) $display("FAIL forwarding step %0d: got %b expected %b", k, got, e);
         else passed++;
         model_cnt(s.clr, e);
      end
   endtask

   task automatic test_load_use();
      in_t  s;
      out_t e, got;
      for (int k = 0; k < 7; k++) begin
         s = '0;
         e = '0;
         case (k)
            0: s.clr = 1'b1;
            1: begin s = lw_in(); e = lw_out(); end
            3: begin s.rsrc = 2'b01; s.rde = 0; s.rs1d = 0; end
            4: begin s.rsrc = 2'b10; s.rde = 3; s.rs1d = 3; end
            5: begin s.rsrc = 2'b01; s.rde = 3; s.rs1d = 3; e = lw_out(); end
            default: ;
         endcase
         drive(s, e);
         @(negedge clk);
         got = sample();
         e = sb.pop_front();
         checks++;
         if (got !== e) $display("FAIL load_use step %0d: got %b expected %b", k, got, e);
         else passed++;
         checks++;
         if ((stall_cnt !== m_stall) || (flush_cnt !== m_flush))
            $display("FAIL load_use_cnt step %0d: got %0d/%0d expected %0d/%0d",
                     k, stall_cnt, flush_cnt, m_stall, m_flush);
         else passed++;
         if (k == 2) begin
            checks++;
            if ((stall_cnt !== 4'd1) || (flush_cnt !== 4'd1))
               $display("FAIL load_use_single: got %0d/%0d expected 1/1", stall_cnt, flush_cnt);
            else passed++;
         end
         model_cnt(s.clr, e);
      end
   endtask

   task automatic test_mem_wait();
      in_t  s;
      out_t e, got;
      for (int k = 0; k < 7; k++) begin
         s = '0;
         s.rs1e = 5'd4; s.rdm = 5'd4; s.rwm = 1'b1;
         s.mem = (k < 6);
         e = '0;
         e.fa = 2'b10;
         if ((k == 0) || (k == 1) || (k == 3) || (k == 4)) e = mem_out(2'b10);
         drive(s, e);
         @(negedge clk);
         got = sample();
         e = sb.pop_front();
         checks++;
         if (got !== e) $display("FAIL mem_wait step %0d: got %b expected %b", k, got, e);
         else passed++;
         model_cnt(s.clr, e);
      end
   endtask

   task automatic test_priority();
      in_t  s;
      out_t e, got;
      for (int k = 0; k < 6; k++) begin
         s = lw_in();
         e = '0;
         case (k)
            0, 1: begin s.pcsrc = 1; s.mem = 1; e = mem_out(2'b00); end
            2:    begin s.pcsrc = 1; s.mem = 1; e = redir_out(); end
            3:    e = lw_out();
            4:    begin s.pcsrc = 1; e = redir_out(); end
            default: s = '0;
         endcase
         drive(s, e);
         @(negedge clk);
         got = sample();
         e = sb.pop_front();
         checks++;
         if (got !== e) $display("FAIL priority step %0d: got %b expected %b", k, got, e);
         else passed++;
         model_cnt(s.clr, e);
      end
   endtask

   task automatic test_reset_in_wait();
      in_t  s;
      out_t e, got, z;
      z = '0;
      for (int k = 0; k < 2; k++) begin
         s = '0;
         s.mem = 1'b1;
         drive(s, mem_out(2'b00));
         @(negedge clk);
         got = sample();
         e = sb.pop_front();
         checks++;
         if (got !== e) $display("FAIL wait_before_reset step %0d: got %b expected %b", k, got, e);
         else passed++;
         model_cnt(s.clr, e);
      end
      // Pulse reset between edges while the FSM sits in WAIT.
      #2;
      reset = 1'b1;
      sb.push_back(z);
      #1;
      got = sample();
      e = sb.pop_front();
      checks++;
      if (got !== e) $display("FAIL reset_in_wait_outputs: got %b expected %b", got, e);
      else passed++;
      checks++;
      if ((stall_cnt !== 4'd0) || (flush_cnt !== 4'd0))
         $display("FAIL reset_in_wait_counters: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
      else passed++;
      m_stall = 4'd0;
      m_flush = 4'd0;
      #1;
      reset = 1'b0;
      s = '0;
      apply(s);
      for (int k = 0; k < 4; k++) begin
         s = '0;
         s.mem = (k < 3);
         e = (k < 2) ? mem_out(2'b00) : z;
         drive(s, e);
         @(negedge clk);
         got = sample();
         e = sb.pop_front();
         checks++;
         if (got !== e) $display("FAIL wait_after_reset step %0d: got %b expected %b", k, got, e);
         else passed++;
         model_cnt(s.clr, e);
      end
   endtask

   task automatic test_saturation();
      in_t  s;
      out_t e, got;
      for (int k = 0; k < 25; k++) begin
         s = '0;
         e = '0;
         if (k == 0) s.clr = 1'b1;
         else if (k <= 20) begin s = lw_in(); e = lw_out(); end
         else if (k == 22) begin s = lw_in(); s.clr = 1'b1; e = lw_out(); end
         drive(s, e);
         @(negedge clk);
         got = sample();
         e = sb.pop_front();
         checks++;
         if (got !== e) $display("FAIL saturation step %0d: got %b expected %b", k, got, e);
         else passed++;
         checks++;
         if ((stall_cnt !== m_stall) || (flush_cnt !== m_flush))
            $display("FAIL saturation_cnt step %0d: got %0d/%0d expected %0d/%0d",
                     k, stall_cnt, flush_cnt, m_stall, m_flush);
         else passed++;
         if (k == 21) begin
            checks++;
            if ((stall_cnt !== 4'd15) || (flush_cnt !== 4'd15))
               $display("FAIL saturation_top: got %0d/%0d expected 15/15", stall_cnt, flush_cnt);
            else passed++;
         end
         if (k == 23) begin
            checks++;
            if ((stall_cnt !== 4'd0) || (flush_cnt !== 4'd0))
               $display("FAIL clear_overrides_inc: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
            else passed++;
         end
         model_cnt(s.clr, e);
      end
   endtask

   initial begin
      test_reset();
      test_forwarding();
      test_load_use();
      test_mem_wait();
      test_priority();
      test_reset_in_wait();
      test_saturation();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/hazard_unit_mc.md
HAZARD_UNIT_MC -- requirements
Module: hazard_unit_mc

Interface
REQ-001 Parameter REG_AW, default 5, register-address width.
REQ-002 Parameter MEM_LAT, default 2, extra data-memory wait cycles per load/store (0..15); 0 means single-cycle memory.
REQ-003 Parameter CNT_W, default 16, performance-counter width.
REQ-004 clk  in  1  rising-edge clock; reset  in  1  asynchronous, active-high reset.
REQ-005 Rs1D, Rs2D  in  REG_AW each  source registers in Decode.
REQ-006 Rs1E, Rs2E, RdE  in  REG_AW each  source and destination registers in Execute.
REQ-007 RdM, RdW  in  REG_AW each  destination registers in Memory and Writeback.
REQ-008 RegWriteM, RegWriteW  in  1 each  register-write enables in Memory and Writeback.
REQ-009 ResultSrcE  in  2  Execute result select; 2'b01 marks a load.
REQ-010 PCSrcE  in  1  taken branch, jump or jalr in Execute.
REQ-011 MemAccessM  in  1  load or store in Memory.
REQ-012 perf_clr  in  1  synchronous clear of the performance counters.
REQ-013 ForwardAE, ForwardBE  out  2 each  operand bypass select: 00 register file, 01 Writeback result, 10 Memory ALU result.
REQ-014 StallF, StallD, StallE, StallM  out  1 each  active-high hold of the PC and the F/D, D/E, E/M registers.
REQ-015 FlushD, FlushE, FlushW  out  1 each  active-high bubble insert into the F/D, D/E, M/W registers.
REQ-016 stall_cnt, flush_cnt  out  CNT_W each  saturating performance counters.

Function
REQ-017 ForwardAE is 10 when RegWriteM is 1, RdM is nonzero and RdM equals Rs1E; otherwise 01 when RegWriteW is 1, RdW is nonzero and RdW equals Rs1E; otherwise 00. ForwardBE follows the same rule using Rs2E.
REQ-018 lwStall is 1 when ResultSrcE equals 01, RdE is nonzero, and RdE equals Rs1D or Rs2D.
REQ-019 The memory-wait FSM has three states: IDLE, WAIT and RELEASE, with a 4-bit down-counter wcnt.
REQ-020 In IDLE with MemAccessM=1 and MEM_LAT>0: memStall=1 combinationally; wcnt loads MEM_LAT-1; next state is RELEASE if MEM_LAT=1, otherwise WAIT.
REQ-021 In WAIT: memStall=1; wcnt decrements; the FSM moves to RELEASE on the edge where wcnt=1.
REQ-022 In RELEASE: memStall=0, so the access leaves Memory; next state is IDLE.
REQ-023 With MEM_LAT=0 the FSM stays in IDLE and memStall is always 0.
REQ-024 Result: each memory access holds Memory for exactly MEM_LAT extra cycles; back-to-back accesses each incur MEM_LAT.
REQ-025 Priority 1, memStall=1: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0, whatever lwStall or PCSrcE are.
REQ-026 Priority 2, PCSrcE=1: FlushD=FlushE=1, StallF=StallD=0 so the redirect is taken even when lwStall=1.
REQ-027 Priority 3, lwStall=1: StallF=StallD=1 and FlushE=1.
REQ-028 An outcome that none of REQ-025..027 asserts is 0.
REQ-029 A PCSrcE held during memStall takes effect in the first cycle after memStall deasserts, because Execute stays frozen.
REQ-030 stall_cnt increments on each cycle with StallF=1.
REQ-031 flush_cnt increments on each cycle with FlushE=1.
REQ-032 Both counters saturate at all-ones.
REQ-033 perf_clr=1 zeroes both counters on the next edge and overrides an increment in the same cycle.

Reset
REQ-034 While reset=1: FSM is IDLE, wcnt=0, stall_cnt=flush_cnt=0.
REQ-035 While reset=1: all Stall and Flush outputs are 0 and ForwardAE=ForwardBE=00, independent of the other inputs.
REQ-036 An assertion of reset during WAIT aborts the wait immediately, without waiting for a clock edge.
REQ-037 After reset deasserts, the first edge samples MemAccessM from the IDLE state.

Verification
REQ-038 Forwarding: RdM=RdW=Rs1E=5, RegWriteM=RegWriteW=1 -> ForwardAE=10; RdM=0 with the rest unchanged -> ForwardAE=01; Rs2E=0 matching RdW=0 -> ForwardBE=00.
REQ-039 Load-use: ResultSrcE=01, RdE=3, Rs2D=3 -> StallF=StallD=FlushE=1 for one cycle; stall_cnt=1 and flush_cnt=1 afterwards.
REQ-040 Memory wait with MEM_LAT=2: MemAccessM=1 held -> StallM=FlushW=1 for exactly 2 cycles, 0 in the third cycle; a second access then stalls 2 more cycles.
REQ-041 Simultaneous events: PCSrcE=1, lwStall=1 and MemAccessM=1 -> memStall priority for MEM_LAT cycles; then FlushD=FlushE=1 and StallF=0.
REQ-042 Reset in WAIT: reset asserted mid-wait -> all outputs 0 immediately; after release, a new access stalls the full MEM_LAT cycles.
REQ-043 Saturation with CNT_W=4: 20 stall cycles -> stall_cnt=15; perf_clr=1 in the same cycle as a stall -> 0.
